// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl
// Forwarding and hazard controller for the 5-stage RV32 pipeline.
//
// Purpose:
//   - Chooses the EX-stage forwarding mux legs (Forward1/Forward2).
//   - Holds the WB+1 capture register. It feeds the mux's fourth leg with
//     the value the regfile committed on the previous advancing edge.
//   - Raises load-use stall/bubble and memory-wait freeze controls.
//   - Counts stalled cycles in a saturating counter.
//
// Ports:
//   clk, rst (async, active-low)       clock / reset
//   mem_stall                          IM/DM not ready, freeze everything
//   IF_ID_rs1/rs2, *_used              sources of the instruction in ID
//   ID_EX_rs1/rs2, ID_EX_rd, _MemRead  instruction in EX
//   EX_MEM_rd, _RegWrite, _MemRead     instruction in MEM
//   MEM_WB_rd, _RegWrite, WB_RegData   instruction in WB and its value
//   Forward1/2                         00 regfile, 10 EX/MEM, 01 WB, 11 WB+1
//   WB_RegData_out                     captured WB+1 data
//   PC_write, IF_ID_write              front-end update enables
//   ID_EX_bubble                       insert NOP into ID/EX
//   stall_cnt                          saturating count of PC_write=0 cycles
module fwd_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_stall,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic             IF_ID_rs1_used,
    input  logic             IF_ID_rs2_used,
    input  logic [4:0]       ID_EX_rs1,
    input  logic [4:0]       ID_EX_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       MEM_WB_rd,
    input  logic             MEM_WB_RegWrite,
    input  logic [31:0]      WB_RegData,
    output logic [1:0]       Forward1,
    output logic [1:0]       Forward2,
    output logic [31:0]      WB_RegData_out,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             ID_EX_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    // ------------------------------------------------------------------
    // WB+1 capture register
    // ------------------------------------------------------------------
    logic        cap_valid_q, cap_valid_d;
    logic [4:0]  cap_rd_q,    cap_rd_d;
    logic [31:0] cap_data_q,  cap_data_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Per-source views so both operands share one generate body.
    logic [4:0] ex_rs    [2];
    logic [4:0] id_rs    [2];
    logic       id_used  [2];
    logic [1:0] fwd_sel  [2];
    logic       lu_src   [2];
    logic       lu;
    logic       freeze;

    assign ex_rs[0]   = ID_EX_rs1;
    assign ex_rs[1]   = ID_EX_rs2;
    assign id_rs[0]   = IF_ID_rs1;
    assign id_rs[1]   = IF_ID_rs2;
    assign id_used[0] = IF_ID_rs1_used;
    assign id_used[1] = IF_ID_rs2_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            // Priority chain, nearest producer first. A load in MEM has no
            // data yet, so it is skipped and older producers are considered.
            assign fwd_sel[gi] =
                (ex_rs[gi] == 5'd0)                                    ? 2'b00 :
                (EX_MEM_RegWrite && !EX_MEM_MemRead &&
                 EX_MEM_rd == ex_rs[gi])                               ? 2'b10 :
                (MEM_WB_RegWrite && MEM_WB_rd == ex_rs[gi])            ? 2'b01 :
                (cap_valid_q && cap_rd_q == ex_rs[gi])                 ? 2'b11 :
                                                                         2'b00;

            // Load data only appears in WB, so a load in either EX or MEM
            // blocks a dependent instruction in ID.
            assign lu_src[gi] = id_used[gi] && (id_rs[gi] != 5'd0) &&
                                ((ID_EX_MemRead  && ID_EX_rd  == id_rs[gi]) ||
                                 (EX_MEM_MemRead && EX_MEM_rd == id_rs[gi]));
        end
    endgenerate

    assign Forward1 = fwd_sel[0];
    assign Forward2 = fwd_sel[1];
    assign lu       = lu_src[0] || lu_src[1];

    // A memory wait freezes everything and suppresses the bubble; the
    // load-use check is simply re-evaluated once the freeze lifts.
    assign freeze       = lu || mem_stall;
    assign PC_write     = !freeze;
    assign IF_ID_write  = !freeze;
    assign ID_EX_bubble = lu && !mem_stall;

    always_comb begin
        cap_valid_d = cap_valid_q;
        cap_rd_d    = cap_rd_q;
        cap_data_d  = cap_data_q;
        if (!mem_stall) begin
            cap_valid_d = MEM_WB_RegWrite && (MEM_WB_rd != 5'd0);
            cap_rd_d    = MEM_WB_rd;
            cap_data_d  = WB_RegData;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_valid_q <= 1'b0;
            cap_rd_q    <= 5'd0;
            cap_data_q  <= 32'd0;
            stall_cnt_q <= '0;
        end else begin
            cap_valid_q <= cap_valid_d;
            cap_rd_q    <= cap_rd_d;
            cap_data_q  <= cap_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign WB_RegData_out = cap_data_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed testbench for fwd_hazard_ctrl with hand-computed expectations.
// The DUT uses a 4-bit stall counter so saturation is reachable quickly.
module tb_fwd_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             mem_stall;
    logic [4:0]       IF_ID_rs1, IF_ID_rs2;
    logic             IF_ID_rs1_used, IF_ID_rs2_used;
    logic [4:0]       ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic             ID_EX_MemRead;
    logic [4:0]       EX_MEM_rd;
    logic             EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]       MEM_WB_rd;
    logic             MEM_WB_RegWrite;
    logic [31:0]      WB_RegData;
    logic [1:0]       Forward1, Forward2;
    logic [31:0]      WB_RegData_out;
    logic             PC_write, IF_ID_write, ID_EX_bubble;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fwd_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_stall       (mem_stall),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .IF_ID_rs1_used  (IF_ID_rs1_used),
        .IF_ID_rs2_used  (IF_ID_rs2_used),
        .ID_EX_rs1       (ID_EX_rs1),
        .ID_EX_rs2       (ID_EX_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_MemRead   (ID_EX_MemRead),
        .EX_MEM_rd       (EX_MEM_rd),
        .EX_MEM_RegWrite (EX_MEM_RegWrite),
        .EX_MEM_MemRead  (EX_MEM_MemRead),
        .MEM_WB_rd       (MEM_WB_rd),
        .MEM_WB_RegWrite (MEM_WB_RegWrite),
        .WB_RegData      (WB_RegData),
        .Forward1        (Forward1),
        .Forward2        (Forward2),
        .WB_RegData_out  (WB_RegData_out),
        .PC_write        (PC_write),
        .IF_ID_write     (IF_ID_write),
        .ID_EX_bubble    (ID_EX_bubble),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("  ok  %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic clear_inputs();
        mem_stall       = 1'b0;
        IF_ID_rs1       = 5'd0;
        IF_ID_rs2       = 5'd0;
        IF_ID_rs1_used  = 1'b0;
        IF_ID_rs2_used  = 1'b0;
        ID_EX_rs1       = 5'd0;
        ID_EX_rs2       = 5'd0;
        ID_EX_rd        = 5'd0;
        ID_EX_MemRead   = 1'b0;
        EX_MEM_rd       = 5'd0;
        EX_MEM_RegWrite = 1'b0;
        EX_MEM_MemRead  = 1'b0;
        MEM_WB_rd       = 5'd0;
        MEM_WB_RegWrite = 1'b0;
        WB_RegData      = 32'd0;
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1;
        // ---------------- reset state ----------------
        chk("rst_wb_out",   WB_RegData_out, 32'd0);
        chk("rst_cnt",      32'(stall_cnt), 32'd0);
        chk("rst_pc_write", 32'(PC_write),  32'd1);
        chk("rst_bubble",   32'(ID_EX_bubble), 32'd0);
        step();
        step();
        rst = 1'b1;

        // ---------------- EX/MEM forwarding ----------------
        // add x5 in MEM (and x5 also in WB: MEM must win), sub reads x5, x0
        ID_EX_rs1 = 5'd5; ID_EX_rs2 = 5'd0;
        EX_MEM_rd = 5'd5; EX_MEM_RegWrite = 1'b1;
        MEM_WB_rd = 5'd5; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("fwd_exmem_f1", 32'(Forward1), 32'd2);
        chk("fwd_exmem_f2", 32'(Forward2), 32'd0);
        // load in MEM is skipped, WB match wins
        EX_MEM_MemRead = 1'b1;
        #1;
        chk("fwd_ld_skip_f1", 32'(Forward1), 32'd1);
        chk("fwd_ld_pcw",     32'(PC_write), 32'd1);
        clear_inputs();
        step();

        // ---------------- WB+1 capture ----------------
        MEM_WB_rd = 5'd7; MEM_WB_RegWrite = 1'b1; WB_RegData = 32'hDEADBEEF;
        step();
        clear_inputs();
        ID_EX_rs2 = 5'd7;
        #1;
        chk("cap_f2",     32'(Forward2), 32'd3);
        chk("cap_wb_out", WB_RegData_out, 32'hDEADBEEF);
        MEM_WB_rd = 5'd7; MEM_WB_RegWrite = 1'b1;
        #1;
        chk("cap_wb_prio_f2", 32'(Forward2), 32'd1);
        clear_inputs();
        step();
        ID_EX_rs2 = 5'd7;
        #1;
        chk("cap_cleared_f2", 32'(Forward2), 32'd0);
        clear_inputs();

        // ---------------- load-use, 2 bubbles ----------------
        // cycle 1: lw x3 in EX, consumer in ID reads x3
        IF_ID_rs1 = 5'd3; IF_ID_rs1_used = 1'b1;
        ID_EX_rd = 5'd3; ID_EX_MemRead = 1'b1;
        #1;
        chk("lu1_pcw",    32'(PC_write),     32'd0);
        chk("lu1_ifidw",  32'(IF_ID_write),  32'd0);
        chk("lu1_bubble", 32'(ID_EX_bubble), 32'd1);
        step();
        // cycle 2: load in MEM, bubble in EX
        ID_EX_rd = 5'd0; ID_EX_MemRead = 1'b0;
        EX_MEM_rd = 5'd3; EX_MEM_RegWrite = 1'b1; EX_MEM_MemRead = 1'b1;
        #1;
        chk("lu2_pcw",    32'(PC_write),     32'd0);
        chk("lu2_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("lu2_cnt",    32'(stall_cnt),    32'd1);
        step();
        // cycle 3: load in WB, consumer reads x3 in EX
        EX_MEM_rd = 5'd0; EX_MEM_RegWrite = 1'b0; EX_MEM_MemRead = 1'b0;
        MEM_WB_rd = 5'd3; MEM_WB_RegWrite = 1'b1; WB_RegData = 32'h12345678;
        ID_EX_rs1 = 5'd3;
        #1;
        chk("lu3_pcw",    32'(PC_write),     32'd1);
        chk("lu3_bubble", 32'(ID_EX_bubble), 32'd0);
        chk("lu3_f1",     32'(Forward1),     32'd1);
        chk("lu3_cnt",    32'(stall_cnt),    32'd2);
        step();
        chk("lu_end_cnt", 32'(stall_cnt), 32'd2);

        // ---------------- multi-cycle mem_stall ----------------
        // capture now holds x3 = 0x12345678; also raise a load-use
        clear_inputs();
        mem_stall = 1'b1;
        IF_ID_rs1 = 5'd3; IF_ID_rs1_used = 1'b1;
        ID_EX_rd = 5'd3; ID_EX_MemRead = 1'b1;
        ID_EX_rs2 = 5'd3;
        for (int i = 0; i < 5; i++) begin
            MEM_WB_RegWrite = i[0];
            MEM_WB_rd       = (i[0]) ? 5'd9 : 5'd10;
            WB_RegData      = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("ms%0d_bubble", i), 32'(ID_EX_bubble), 32'd0);
            chk($sformatf("ms%0d_pcw", i),    32'(PC_write),     32'd0);
            chk($sformatf("ms%0d_wbout", i),  WB_RegData_out,    32'h12345678);
            chk($sformatf("ms%0d_f2", i),     32'(Forward2),     32'd3);
            step();
        end
        chk("ms_cnt", 32'(stall_cnt), 32'd7);
        // freeze released, load-use still present: bubble now issues
        mem_stall = 1'b0;
        MEM_WB_RegWrite = 1'b0;
        #1;
        chk("ms_rel_bubble", 32'(ID_EX_bubble), 32'd1);
        chk("ms_rel_pcw",    32'(PC_write),     32'd0);

        // ---------------- async reset mid-stall ----------------
        clear_inputs();
        mem_stall = 1'b1;
        ID_EX_rs1 = 5'd3;
        #1;
        chk("pre_rst_f1",    32'(Forward1),  32'd3);
        rst = 1'b0;
        #1;
        chk("arst_wb_out", WB_RegData_out,  32'd0);
        chk("arst_cnt",    32'(stall_cnt),  32'd0);
        chk("arst_f1",     32'(Forward1),   32'd0);
        step();
        step();
        mem_stall = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_f1", 32'(Forward1), 32'd0);
        step();
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);

        // ---------------- counter saturation ----------------
        clear_inputs();
        mem_stall = 1'b1;
        repeat (14) step();
        chk("sat_cnt14", 32'(stall_cnt), 32'd14);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("sat_cnt_more%0d", i), 32'(stall_cnt), 32'd15);
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage RV32 pipeline. It generates the `Forward1`/`Forward2` select codes consumed by the EX-stage forwarding mux. It also owns the WB+1 capture register that drives the mux's `WB_RegData_out` leg. Finally, it produces the load-use stall/bubble and memory-wait freeze controls for PC, IF/ID and ID/EX, and a stall-cycle performance counter.

## Interface
- `CNT_W`, 32, width of the stall-cycle counter.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_stall`  in  1  IM or DM not ready; freezes every pipeline register.
- `IF_ID_rs1`, `IF_ID_rs2`  in  5  source registers of the instruction in ID.
- `IF_ID_rs1_used`, `IF_ID_rs2_used`  in  1  source actually read by that instruction.
- `ID_EX_rs1`, `ID_EX_rs2`  in  5  source registers of the instruction in EX.
- `ID_EX_rd`  in  5  destination register in EX.
- `ID_EX_MemRead`  in  1  EX instruction is a load.
- `EX_MEM_rd`  in  5  destination register in MEM.
- `EX_MEM_RegWrite`  in  1  MEM instruction writes rd.
- `EX_MEM_MemRead`  in  1  MEM instruction is a load.
- `MEM_WB_rd`  in  5  destination register in WB.
- `MEM_WB_RegWrite`  in  1  WB instruction writes rd.
- `WB_RegData`  in  32  value being written back this cycle.
- `Forward1`, `Forward2`  out  2  mux selects: 00 regfile, 10 EX/MEM ALU result, 01 WB data, 11 captured WB+1 data.
- `WB_RegData_out`  out  32  captured WB+1 data.
- `PC_write`, `IF_ID_write`  out  1  enable PC / IF/ID update.
- `ID_EX_bubble`  out  1  load NOP into ID/EX this edge.
- `stall_cnt`  out  CNT_W  cycles with `PC_write`=0, saturating.

## Operation
- **Capture register** (`cap_valid`, `cap_rd[4:0]`, `cap_data[31:0]`):
  - On each edge with `mem_stall`=0: `cap_valid` <= `MEM_WB_RegWrite` && `MEM_WB_rd`!=0; `cap_rd` <= `MEM_WB_rd`; `cap_data` <= `WB_RegData`.
  - With `mem_stall`=1: all three hold.
  - `WB_RegData_out` = `cap_data`.
- **Forward select**, per source rs (rs1 → `Forward1`, rs2 → `Forward2`), first match wins:
  - rs==0 → 00.
  - `EX_MEM_RegWrite` && !`EX_MEM_MemRead` && `EX_MEM_rd`==rs → 10. A load in MEM is never forwarded; evaluation falls through to the next rule.
  - `MEM_WB_RegWrite` && `MEM_WB_rd`==rs && rs!=0 → 01.
  - `cap_valid` && `cap_rd`==rs → 11.
  - otherwise → 00.
- **Load-use hazard** `lu` = 1 when, for either used IF/ID source rs!=0:
  - (`ID_EX_MemRead` && `ID_EX_rd`==rs), or
  - (`EX_MEM_MemRead` && `EX_MEM_rd`==rs).
  - This gives 2 bubbles per adjacent load-use, because DM data is available only in WB.
- **Stall controls:**
  - `PC_write` = `IF_ID_write` = !(`lu` || `mem_stall`).
  - `ID_EX_bubble` = `lu` && !`mem_stall`. `mem_stall` has priority: freeze, no bubble.
- **Stall counter:** increments on each edge with `PC_write`=0. It saturates at all-ones and never wraps.

## Timing
- `Forward1/2`, `PC_write`, `IF_ID_write` and `ID_EX_bubble` are combinational, valid the same cycle as their inputs.
- `WB_RegData_out` is registered. It equals the WB value from the previous non-stalled cycle, i.e. exactly the instruction the regfile just committed. This covers the case where ID latched stale regfile data at the same edge as the write.
- Reset (`rst`=0, async): `cap_valid`=0, `cap_rd`=0, `cap_data`=0, `WB_RegData_out`=0, `stall_cnt`=0.
  - While in reset, combinational outputs follow inputs with no capture hits.
  - Reset mid-stall discards the capture; the first cycle after release has no 11 selects.
- `mem_stall` and `lu` in the same cycle:
  - Freeze: no bubble; the counter increments once.
  - `lu` is re-evaluated after the freeze releases.
- Multi-cycle `mem_stall`: capture holds for its full duration, so forwarding codes stay stable while EX is frozen.
- `lu` lasting 2 cycles: the counter advances 2.

## Test plan
- `add x5` in MEM, `sub` in EX reading x5/x0 → `Forward1`=10, `Forward2`=00. Repeat with `EX_MEM_MemRead`=1 and `MEM_WB_rd`=5 → `Forward1`=01.
- WB writes x7=0xDEADBEEF with `mem_stall`=0. Next cycle EX reads rs2=x7, no EX/MEM or MEM/WB match → `Forward2`=11, `WB_RegData_out`=0xDEADBEEF.
- `lw x3` in EX, ID reads x3 → cycle 1: `PC_write`=0, `ID_EX_bubble`=1. Cycle 2 (load in MEM): same. Cycle 3: `PC_write`=1, consumer in EX sees `Forward1`=01. `stall_cnt` ends at 2.
- Hold `mem_stall`=1 for 5 cycles with WB activity toggling → `cap_*` and `WB_RegData_out` unchanged, `ID_EX_bubble`=0 throughout, `stall_cnt`+=5.
- Preload `stall_cnt` near saturation (`CNT_W`=4, 14 stall cycles), then 3 more stall cycles → count 15, no wrap.
- Assert `rst`=0 mid-`mem_stall` with `cap_valid`=1 → `WB_RegData_out`=0 immediately (async). After release, a matching rs gives `Forward`=00.
